// File: rtl/trap_pkg.sv
// Shared types and constants for the trap sprite controller.
package trap_pkg;

    typedef enum logic [1:0] {
        HIDDEN  = 2'd0,
        RISING  = 2'd1,
        ARMED   = 2'd2,
        RETRACT = 2'd3
    } trap_state_t;

    localparam int unsigned SPR_W_DEF  = 20;
    localparam int unsigned SPR_H_DEF  = 22;
    localparam logic [11:0] TRANSP_DEF = 12'h808;

    // Extension in rows; holds 0..SPR_H (sprite heights up to 31).
    localparam int unsigned EXT_W = 5;

    // Counter width that covers the largest initial hidden count (last
    // trap's stagger) and the armed dwell time.
    function automatic int unsigned cnt_width(input int unsigned n_traps,
                                              input int unsigned hide_frames,
                                              input int unsigned arm_frames,
                                              input int unsigned phase_frames);
        int unsigned m;
        m = hide_frames + (n_traps - 1) * phase_frames;
        if (arm_frames > m) m = arm_frames;
        return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/trap_anim_fsm.sv
// Per-trap pop-up animation: hidden -> rising -> armed -> retracting,
// stepped once per video frame.
module trap_anim_fsm
    import trap_pkg::*;
#(
    parameter int unsigned SPR_H       = SPR_H_DEF,
    parameter int unsigned STEP        = 2,
    parameter int unsigned HIDE_FRAMES = 90,
    parameter int unsigned ARM_FRAMES  = 60,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             frame_start,
    input  logic             en,
    input  logic [CNT_W-1:0] init_cnt,
    output logic [EXT_W-1:0] ext,
    output logic             armed
);

    localparam logic [EXT_W-1:0] EXT_FULL = EXT_W'(SPR_H);
    localparam logic [EXT_W-1:0] EXT_STEP = EXT_W'(STEP);
    localparam logic [CNT_W-1:0] HIDE_CNT = CNT_W'(HIDE_FRAMES);
    localparam logic [CNT_W-1:0] ARM_CNT  = CNT_W'(ARM_FRAMES);

    trap_state_t      state_q, state_d;
    logic [EXT_W-1:0] ext_q, ext_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [EXT_W:0]   ext_up;

    // Next-state logic; a disabled trap is forced hidden regardless of frame_start.
    always_comb begin
        state_d = state_q;
        ext_d   = ext_q;
        cnt_d   = cnt_q;
        ext_up  = {1'b0, ext_q} + {1'b0, EXT_STEP};
        if (!en) begin
            state_d = HIDDEN;
            ext_d   = '0;
            cnt_d   = HIDE_CNT;
        end else if (frame_start) begin
            case (state_q)
                HIDDEN: begin
                    ext_d = '0;
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = RISING;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                RISING: begin
                    if (ext_up >= {1'b0, EXT_FULL}) begin
                        ext_d   = EXT_FULL;
                        cnt_d   = ARM_CNT;
                        state_d = ARMED;
                    end else begin
                        ext_d = ext_up[EXT_W-1:0];
                    end
                end
                ARMED: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = RETRACT;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                RETRACT: begin
                    // Saturating retract: never wraps below zero.
                    if (ext_q <= EXT_STEP) begin
                        ext_d   = '0;
                        cnt_d   = HIDE_CNT;
                        state_d = HIDDEN;
                    end else begin
                        ext_d = ext_q - EXT_STEP;
                    end
                end
                default: begin
                    state_d = HIDDEN;
                    ext_d   = '0;
                    cnt_d   = HIDE_CNT;
                end
            endcase
        end
    end

    // State register; reset loads this trap's staggered hidden count.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= HIDDEN;
            ext_q   <= '0;
            cnt_q   <= init_cnt;
        end else begin
            state_q <= state_d;
            ext_q   <= ext_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ext   = ext_q;
    assign armed = (state_q == ARMED);

endmodule

// File: rtl/trap_sprite_ctrl.sv
// Shares one trap sprite ROM among N_TRAPS animated trap instances and
// produces a 2-cycle pipelined colour/transparency result per pixel.
module trap_sprite_ctrl
    import trap_pkg::*;
#(
    parameter int unsigned N_TRAPS      = 4,
    parameter int unsigned SPR_W        = SPR_W_DEF,
    parameter int unsigned SPR_H        = SPR_H_DEF,
    parameter int unsigned STEP         = 2,
    parameter int unsigned HIDE_FRAMES  = 90,
    parameter int unsigned ARM_FRAMES   = 60,
    parameter int unsigned PHASE_FRAMES = 30,
    parameter logic [11:0] TRANSP       = TRANSP_DEF
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  frame_start,
    input  logic [9:0]            DrawX,
    input  logic [9:0]            DrawY,
    input  logic [N_TRAPS-1:0]    trap_en,
    input  logic [N_TRAPS*10-1:0] trap_x,
    input  logic [N_TRAPS*10-1:0] trap_y,
    output logic [8:0]            rom_addr,
    input  logic [11:0]           rom_color,
    output logic                  pix_valid,
    output logic [11:0]           pix_color,
    output logic [N_TRAPS-1:0]    armed
);

    localparam int unsigned CNT_W = cnt_width(N_TRAPS, HIDE_FRAMES, ARM_FRAMES, PHASE_FRAMES);

    logic [EXT_W-1:0] ext [N_TRAPS];

    for (genvar g = 0; g < N_TRAPS; g++) begin : g_trap
        trap_anim_fsm #(
            .SPR_H       (SPR_H),
            .STEP        (STEP),
            .HIDE_FRAMES (HIDE_FRAMES),
            .ARM_FRAMES  (ARM_FRAMES),
            .CNT_W       (CNT_W)
        ) u_fsm (
            .Clk         (Clk),
            .Reset_n     (Reset_n),
            .frame_start (frame_start),
            .en          (trap_en[g]),
            .init_cnt    (CNT_W'(HIDE_FRAMES + g * PHASE_FRAMES)),
            .ext         (ext[g]),
            .armed       (armed[g])
        );
    end

    logic [8:0]  addr_q, addr_d;
    logic        hit_q, hit_d;
    logic        pix_valid_q;
    logic [11:0] pix_color_q;
    logic [10:0] px, py, x0, y_base, y_top, row, col;

    // Hit test and ROM address; scanned high-to-low so the lowest index wins.
    // 11-bit arithmetic keeps sprites near the 1023 edge from wrapping.
    always_comb begin
        hit_d  = 1'b0;
        addr_d = addr_q;
        px     = {1'b0, DrawX};
        py     = {1'b0, DrawY};
        x0     = '0;
        y_base = '0;
        y_top  = '0;
        row    = '0;
        col    = '0;
        for (int unsigned k = N_TRAPS; k > 0; k--) begin
            x0     = {1'b0, trap_x[10*(k-1) +: 10]};
            y_base = {1'b0, trap_y[10*(k-1) +: 10]} + 11'(SPR_H);
            y_top  = y_base - 11'(ext[k-1]);
            if ((ext[k-1] != '0) && (px >= x0) && (px < x0 + 11'(SPR_W)) &&
                (py >= y_top) && (py < y_base)) begin
                row    = py - y_top;
                col    = px - x0;
                hit_d  = 1'b1;
                addr_d = 9'(row * 11'(SPR_W) + col);
            end
        end
    end

    // Stage 1: ROM address and hit flag.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            addr_q <= '0;
            hit_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            hit_q  <= hit_d;
        end
    end

    // Stage 2: capture ROM colour and mask transparent pixels.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pix_color_q <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            pix_color_q <= rom_color;
            pix_valid_q <= hit_q && (rom_color != TRANSP);
        end
    end

    assign rom_addr  = addr_q;
    assign pix_valid = pix_valid_q;
    assign pix_color = pix_color_q;

endmodule
